// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, requester
// count, pointer reset value and the request rotation helper.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NREQ = 4;
  localparam logic [1:0] PTR_RST = 2'b11;

  // Rotate right by n so that bit i of the result is x[(i+n) mod 4]
  function automatic logic [NREQ-1:0] rotr4(input logic [NREQ-1:0] x,
                                            input logic [1:0] n);
    logic [2*NREQ-1:0] dbl;
    dbl = {x, x} >> n;
    return dbl[NREQ-1:0];
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder, lowest index wins; y is 00 and
// v is 0 when no input is set.
module prio_enc4 (
  input  logic [3:0] a,
  output logic [1:0] y,
  output logic       v
);

  always_comb begin
    y = 2'd0;
    v = |a;
    if (a[0])      y = 2'd0;
    else if (a[1]) y = 2'd1;
    else if (a[2]) y = 2'd2;
    else if (a[3]) y = 2'd3;
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with hold limit; grants are held until
// done, request withdrawal or the hold limit, then one idle cycle follows.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t          state, state_nxt;
  logic [1:0]      ptr, ptr_nxt;
  logic [3:0]      hcnt, hcnt_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [1:0]      gnt_id_nxt;
  logic            gnt_valid_nxt;
  logic            timeout_nxt;

  logic [NREQ-1:0] rot_req;
  logic [1:0]      enc_y;
  logic            enc_v;
  logic [1:0]      win;
  logic            limit_hit;

  // Rotating the requests puts the slot after the last winner at bit 0
  assign rot_req = rotr4(req, ptr + 2'd1);

  prio_enc4 u_enc (
    .a (rot_req),
    .y (enc_y),
    .v (enc_v)
  );

  assign win       = enc_y + ptr + 2'd1;
  assign limit_hit = (hcnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PTR_RST;
      hcnt      <= 4'd0;
      gnt       <= '0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hcnt      <= hcnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // A withdrawn request or done masks the timeout even on the limit cycle
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hcnt_nxt      = hcnt;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (enc_v) begin
          state_nxt     = GRANT;
          ptr_nxt       = win;
          hcnt_nxt      = 4'd0;
          gnt_nxt       = 4'b0001 << win;
          gnt_id_nxt    = win;
          gnt_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (done || !req[gnt_id] || limit_hit) begin
          state_nxt     = IDLE;
          gnt_nxt       = '0;
          gnt_id_nxt    = 2'd0;
          gnt_valid_nxt = 1'b0;
          timeout_nxt   = limit_hit && !done && req[gnt_id];
        end else begin
          hcnt_nxt = hcnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios with literal checks
// plus randomized traffic compared every cycle against a behavioural model.
module tb_rr_arb4;

  localparam int HOLD_MAX = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'd0;
  logic       done  = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Model state: who owns the resource, how many cycles it has held it
  bit m_busy    = 1'b0;
  int m_owner   = 0;
  int m_ptr     = 3;
  int m_hold    = 0;
  bit m_timeout = 1'b0;

  rr_arb4 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Search the requesters starting just after the last winner
  function automatic int pickNext(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [31:0] expGnt();
    return m_busy ? (32'd1 << m_owner) : 32'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = 4'd0;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_owner   <= 0;
      m_ptr     <= 3;
      m_hold    <= 0;
      m_timeout <= 1'b0;
    end else if (!m_busy) begin
      m_timeout <= 1'b0;
      if (req != 4'd0) begin
        m_busy  <= 1'b1;
        m_owner <= pickNext(req, m_ptr);
        m_ptr   <= pickNext(req, m_ptr);
        m_hold  <= 1;
      end
    end else begin
      m_timeout <= 1'b0;
      if (done || !req[m_owner]) begin
        m_busy <= 1'b0;
      end else if (m_hold == HOLD_MAX) begin
        m_busy    <= 1'b0;
        m_timeout <= 1'b1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_gnt", 32'(gnt), expGnt());
      checkOutput("cyc_valid", 32'(gnt_valid), 32'(m_busy));
      checkOutput("cyc_timeout", 32'(timeout), 32'(m_timeout));
      if (m_busy) checkOutput("cyc_gnt_id", 32'(gnt_id), 32'(m_owner));
    end
  end

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n;

    #1;
    $display("[TB] reset and single requester");
    doReset();
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_valid", 32'(gnt_valid), 32'd0);
    checkOutput("rst_id", 32'(gnt_id), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t1_before_grant", 32'(gnt), 32'd0);
    tick();
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    checkOutput("t1_id", 32'(gnt_id), 32'd0);
    checkOutput("t1_valid", 32'(gnt_valid), 32'd1);
    tick();
    applyStimulus(4'b0001, 1'b1);
    tick();
    checkOutput("t1_release_gnt", 32'(gnt), 32'd0);
    checkOutput("t1_release_valid", 32'(gnt_valid), 32'd0);
    checkOutput("t1_release_timeout", 32'(timeout), 32'd0);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] rotation with all requesting");
    doReset();
    applyStimulus(4'b1111, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (gnt_valid) order.push_back(int'(gnt_id));
      checkOutput("t2_bubble", 32'(gnt_valid), 32'(i % 2));
    end
    checkOutput("t2_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t2_order%0d", i),
                  (i < order.size()) ? 32'(order[i]) : 32'd99, 32'(exp_order[i]));

    $display("[TB] skip over last winner");
    applyStimulus(4'b0101, 1'b0);
    tick();
    checkOutput("t3_gnt", 32'(gnt), 32'h4);
    applyStimulus(4'b0101, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] hold limit");
    applyStimulus(4'b1000, 1'b0);
    tick();
    n = 0;
    while (gnt == 4'b1000 && n < 20) begin
      n++;
      tick();
    end
    checkOutput("t4_hold_cycles", 32'(n), 32'd8);
    checkOutput("t4_timeout", 32'(timeout), 32'd1);
    checkOutput("t4_gnt_dropped", 32'(gnt), 32'd0);
    tick();
    checkOutput("t4_regrant", 32'(gnt), 32'h8);
    checkOutput("t4_timeout_pulse", 32'(timeout), 32'd0);

    $display("[TB] withdrawal and done at limit");
    tick();
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("t5_withdraw_gnt", 32'(gnt), 32'd0);
    checkOutput("t5_withdraw_timeout", 32'(timeout), 32'd0);
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("t5_gnt0", 32'(gnt), 32'h1);
    repeat (7) tick();
    checkOutput("t5_still_held", 32'(gnt), 32'h1);
    applyStimulus(4'b0001, 1'b1);
    tick();
    checkOutput("t5_limit_done_gnt", 32'(gnt), 32'd0);
    checkOutput("t5_limit_done_timeout", 32'(timeout), 32'd0);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] asynchronous reset mid-grant");
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("t6_gnt1", 32'(gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_gnt", 32'(gnt), 32'd0);
    checkOutput("t6_async_valid", 32'(gnt_valid), 32'd0);
    checkOutput("t6_async_id", 32'(gnt_id), 32'd0);
    checkOutput("t6_async_timeout", 32'(timeout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    tick();
    checkOutput("t6_first_after_reset", 32'(gnt), 32'h1);
    checkOutput("t6_first_id", 32'(gnt_id), 32'd0);

    $display("[TB] randomized traffic");
    applyStimulus(4'b0000, 1'b0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 9) == 0);
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
